rename_unit: RTL and testbench

Parametrised, stateful successor to the combinational rename decode. Each cycle it renames a group of up to `WIDTH` RV32 instructions (base ISA plus atomics) from decode. It owns the speculative RAT, the retirement RAT (RRAT) and the physical free list, and resolves intra-group dependencies. It presents a registered, valid/ready-handshaked group to dispatch/ROB, frees registers on commit, and restores state on flush.

---
 rtl/rename_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_rename_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Register rename stage: speculative RAT, retirement RAT and circular free list for RV32 groups.
// Optional macro RENAME_X0_ELIDE_EN stops x0-destination lanes from allocating physical tags.
module rename_unit #(
   parameter int NUM_REGS = 64,
   parameter int WIDTH    = 2,
   localparam int PW      = $clog2(NUM_REGS),
   localparam int IW      = 40 + 3*PW,
   localparam int CW      = $clog2(NUM_REGS) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [WIDTH-1:0]    in_lane_valid,
   input  logic [WIDTH*32-1:0] in_instr,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_lane_valid,
   output logic [WIDTH*IW-1:0] out_instr,
   output logic [WIDTH*5-1:0]  out_arch_rd,
   output logic [WIDTH*PW-1:0] out_phys_rd,
   output logic [WIDTH*PW-1:0] out_old_phys_rd,
   input  logic [WIDTH-1:0]    commit_valid,
   input  logic [WIDTH*5-1:0]  commit_arch_rd,
   input  logic [WIDTH*PW-1:0] commit_phys_rd,
   input  logic [WIDTH*PW-1:0] commit_old_phys_rd,
   input  logic                flush,
   output logic [CW-1:0]       free_count
);

   localparam int DEPTH = NUM_REGS - 32;
   localparam int FIW   = $clog2(DEPTH);
   localparam int FPW   = FIW + 1;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_ATOM  = 7'b0101111;

   logic [PW-1:0]  rat       [32];
   logic [PW-1:0]  rrat      [32];
   logic [PW-1:0]  rrat_nxt  [32];
   logic [PW-1:0]  free_list [DEPTH];
   logic [FPW-1:0] head, tail, rhead;
   logic [FPW-1:0] tail_nxt, rhead_nxt;

   logic [WIDTH-1:0] known, has_rd, has_rs1, has_rs2, alloc, writes_rat;
   logic [4:0]       rd_a [WIDTH];
   logic [4:0]       rs1_a [WIDTH];
   logic [4:0]       rs2_a [WIDTH];
   logic [PW-1:0]    new_tag [WIDTH];
   logic [PW-1:0]    src1_tag [WIDTH];
   logic [PW-1:0]    src2_tag [WIDTH];
   logic [PW-1:0]    old_tag [WIDTH];
   logic [CW-1:0]    alloc_needed;
   logic [CW-1:0]    npush;
   logic             accept;
   logic [WIDTH-1:0] push_en;
   logic [FIW-1:0]   push_idx [WIDTH];
   logic [PW-1:0]    push_val [WIDTH];

   // Pointers carry a wrap bit above the index so full and empty stay distinct.
   function automatic logic [FPW-1:0] ptr_add(input logic [FPW-1:0] p, input int k);
      int   idx;
      logic w;
      idx = int'(p[FIW-1:0]) + k;
      w   = p[FPW-1];
      if (idx >= DEPTH) begin
         idx = idx - DEPTH;
         w   = !w;
      end
      return {w, idx[FIW-1:0]};
   endfunction

   function automatic logic [CW-1:0] ptr_dist(input logic [FPW-1:0] h, input logic [FPW-1:0] t);
      int d;
      if (h[FPW-1] == t[FPW-1]) d = int'(t[FIW-1:0]) - int'(h[FIW-1:0]);
      else                      d = DEPTH - int'(h[FIW-1:0]) + int'(t[FIW-1:0]);
      return d[CW-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         rd_a[i]    = in_instr[i*32+7 +: 5];
         rs1_a[i]   = in_instr[i*32+15 +: 5];
         rs2_a[i]   = in_instr[i*32+20 +: 5];
         known[i]   = 1'b1;
         has_rd[i]  = 1'b0;
         has_rs1[i] = 1'b0;
         has_rs2[i] = 1'b0;
         case (in_instr[i*32 +: 7])
            OP_LUI, OP_AUIPC, OP_JAL: has_rd[i] = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
               has_rd[i]  = 1'b1;
               has_rs1[i] = 1'b1;
            end
            OP_BR, OP_STORE: begin
               has_rs1[i] = 1'b1;
               has_rs2[i] = 1'b1;
            end
            OP_REG, OP_ATOM: begin
               has_rd[i]  = 1'b1;
               has_rs1[i] = 1'b1;
               has_rs2[i] = 1'b1;
            end
            default: known[i] = 1'b0;
         endcase
      end
   end

   // Older lanes of the same group override the RAT; later matches are younger, so they win.
   always_comb begin : rename_lanes
      int             n;
      logic [FPW-1:0] p;
      n = 0;
      p = '0;
      for (int i = 0; i < WIDTH; i++) begin
`ifdef RENAME_X0_ELIDE_EN
         alloc[i] = in_lane_valid[i] && has_rd[i] && (rd_a[i] != 5'd0);
`else
         alloc[i] = in_lane_valid[i] && has_rd[i];
`endif
         writes_rat[i] = alloc[i] && (rd_a[i] != 5'd0);
         p = ptr_add(head, n);
         new_tag[i] = alloc[i] ? free_list[p[FIW-1:0]] : '0;
         if (alloc[i]) n++;
         src1_tag[i] = has_rs1[i] ? rat[rs1_a[i]] : '0;
         src2_tag[i] = has_rs2[i] ? rat[rs2_a[i]] : '0;
         old_tag[i]  = writes_rat[i] ? rat[rd_a[i]] : '0;
         for (int j = 0; j < i; j++) begin
            if (writes_rat[j] && has_rs1[i] && rd_a[j] == rs1_a[i]) src1_tag[i] = new_tag[j];
            if (writes_rat[j] && has_rs2[i] && rd_a[j] == rs2_a[i]) src2_tag[i] = new_tag[j];
            if (writes_rat[j] && writes_rat[i] && rd_a[j] == rd_a[i]) old_tag[i] = new_tag[j];
         end
      end
      alloc_needed = n[CW-1:0];
   end

   assign in_ready = !flush && (!out_valid || out_ready) && (free_count >= alloc_needed);
   assign accept   = in_valid && in_ready;

   // An x0 commit that holds a tag returns that tag itself, since it never displaced a mapping.
   always_comb begin : commit_lanes
      int             np;
      logic [FPW-1:0] t;
      logic [4:0]     ca;
      logic [PW-1:0]  cp;
      np = 0;
      t  = '0;
      rrat_nxt = rrat;
      for (int i = 0; i < WIDTH; i++) begin
         ca = commit_arch_rd[i*5 +: 5];
         cp = commit_phys_rd[i*PW +: PW];
         push_en[i]  = 1'b0;
         push_idx[i] = '0;
         push_val[i] = '0;
         if (commit_valid[i]) begin
            if (ca != 5'd0) rrat_nxt[ca] = cp;
            if (cp != '0) begin
               t = ptr_add(tail, np);
               push_en[i]  = 1'b1;
               push_idx[i] = t[FIW-1:0];
               push_val[i] = (ca == 5'd0) ? cp : commit_old_phys_rd[i*PW +: PW];
               np++;
            end
         end
      end
      npush     = np[CW-1:0];
      tail_nxt  = ptr_add(tail, np);
      rhead_nxt = ptr_add(rhead, np);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            rat[i]  <= PW'(i);
            rrat[i] <= PW'(i);
         end
         for (int i = 0; i < DEPTH; i++) free_list[i] <= PW'(32 + i);
         head            <= '0;
         rhead           <= '0;
         tail            <= {1'b1, {FIW{1'b0}}};
         free_count      <= CW'(DEPTH);
         out_valid       <= 1'b0;
         out_lane_valid  <= '0;
         out_instr       <= '0;
         out_arch_rd     <= '0;
         out_phys_rd     <= '0;
         out_old_phys_rd <= '0;
      end else begin
         assert (int'(free_count) + int'(npush) <= DEPTH);
         for (int i = 0; i < WIDTH; i++)
            if (push_en[i]) free_list[push_idx[i]] <= push_val[i];
         rrat  <= rrat_nxt;
         tail  <= tail_nxt;
         rhead <= rhead_nxt;
         if (flush) begin
            rat        <= rrat_nxt;
            head       <= rhead_nxt;
            free_count <= ptr_dist(rhead_nxt, tail_nxt);
            out_valid  <= 1'b0;
         end else begin
            free_count <= free_count + npush - (accept ? alloc_needed : '0);
            if (accept) begin
               head      <= ptr_add(head, int'(alloc_needed));
               out_valid <= 1'b1;
               out_lane_valid <= in_lane_valid;
               for (int i = 0; i < WIDTH; i++) begin
                  if (writes_rat[i]) rat[rd_a[i]] <= new_tag[i];
                  out_instr[i*IW +: IW] <= (in_lane_valid[i] && known[i]) ?
                     {8'd0, in_instr[i*32 +: 32], src2_tag[i], src1_tag[i], new_tag[i]} : '0;
                  out_arch_rd[i*5 +: 5]      <= (in_lane_valid[i] && has_rd[i]) ? rd_a[i] : 5'd0;
                  out_phys_rd[i*PW +: PW]     <= new_tag[i];
                  out_old_phys_rd[i*PW +: PW] <= old_tag[i];
               end
            end else if (out_ready) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: queue-based rename model checked every cycle plus directed literal checks.
module tb_rename_unit;
   localparam int W  = 2;
   localparam int NR = 64;
   localparam int PW = 6;
   localparam int IW = 40 + 3*PW;
   localparam int CW = 7;
`ifdef RENAME_X0_ELIDE_EN
   localparam bit ELIDE = 1'b1;
`else
   localparam bit ELIDE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid;
   logic [W-1:0]    in_lane_valid;
   logic [W*32-1:0] in_instr;
   logic            in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_lane_valid;
   logic [W*IW-1:0] out_instr;
   logic [W*5-1:0]  out_arch_rd;
   logic [W*PW-1:0] out_phys_rd;
   logic [W*PW-1:0] out_old_phys_rd;
   logic [W-1:0]    commit_valid;
   logic [W*5-1:0]  commit_arch_rd;
   logic [W*PW-1:0] commit_phys_rd;
   logic [W*PW-1:0] commit_old_phys_rd;
   logic            flush;
   logic [CW-1:0]   free_count;

   rename_unit #(.NUM_REGS(NR), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_lane_valid(in_lane_valid),
      .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_valid(out_lane_valid), .out_instr(out_instr), .out_arch_rd(out_arch_rd),
      .out_phys_rd(out_phys_rd), .out_old_phys_rd(out_old_phys_rd),
      .commit_valid(commit_valid), .commit_arch_rd(commit_arch_rd),
      .commit_phys_rd(commit_phys_rd), .commit_old_phys_rd(commit_old_phys_rd),
      .flush(flush), .free_count(free_count));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void dec(input logic [31:0] ins, output bit kn, output bit hrd,
                               output bit hr1, output bit hr2);
      kn = 1; hrd = 0; hr1 = 0; hr2 = 0;
      case (ins[6:0])
         7'b0110111, 7'b0010111, 7'b1101111: hrd = 1;
         7'b1100111, 7'b0000011, 7'b0010011: begin hrd = 1; hr1 = 1; end
         7'b1100011, 7'b0100011:             begin hr1 = 1; hr2 = 1; end
         7'b0110011, 7'b0101111:             begin hrd = 1; hr1 = 1; hr2 = 1; end
         default: kn = 0;
      endcase
   endfunction

   function automatic bit laneAllocs(input logic [31:0] ins, input bit lv);
      bit kn, hrd, hr1, hr2;
      dec(ins, kn, hrd, hr1, hr2);
      return lv && hrd && (!ELIDE || ins[11:7] != 5'd0);
   endfunction

   // Model: sequential per-lane renaming against a map, free tags as a FIFO queue,
   // and the in-flight allocations kept separately so a flush can hand them back.
   int            m_rat [32];
   int            m_rrat [32];
   int            m_free [$];
   int            m_spec [$];
   bit            m_live = 0;
   bit            m_out_valid;
   logic [W-1:0]  m_lv;
   logic [IW-1:0] m_instr [W];
   int            m_arch [W];
   int            m_phys [W];
   int            m_old [W];

   task automatic modelReset();
      for (int i = 0; i < 32; i++) begin m_rat[i] = i; m_rrat[i] = i; end
      m_free.delete();
      m_spec.delete();
      for (int t = 32; t < NR; t++) m_free.push_back(t);
      m_out_valid = 0;
      m_lv = '0;
      for (int l = 0; l < W; l++) begin m_instr[l] = '0; m_arch[l] = 0; m_phys[l] = 0; m_old[l] = 0; end
   endtask

   always @(negedge clk) begin
      int need;
      bit exp_ready;
      need = 0;
      for (int l = 0; l < W; l++) need += int'(laneAllocs(in_instr[l*32 +: 32], in_lane_valid[l]));
      exp_ready = !flush && (!m_out_valid || out_ready) && (m_free.size() >= need);
      if (m_live) begin
         checkOutput("out_valid", 64'(out_valid), 64'(m_out_valid));
         checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
         checkOutput("free_count", 64'(free_count), 64'(m_free.size()));
         if (m_out_valid) begin
            checkOutput("out_lane_valid", 64'(out_lane_valid), 64'(m_lv));
            for (int l = 0; l < W; l++) begin
               checkOutput($sformatf("out_instr[%0d]", l), 64'(out_instr[l*IW +: IW]), 64'(m_instr[l]));
               checkOutput($sformatf("out_arch_rd[%0d]", l), 64'(out_arch_rd[l*5 +: 5]), 64'(m_arch[l]));
               checkOutput($sformatf("out_phys_rd[%0d]", l), 64'(out_phys_rd[l*PW +: PW]), 64'(m_phys[l]));
               checkOutput($sformatf("out_old_phys_rd[%0d]", l), 64'(out_old_phys_rd[l*PW +: PW]), 64'(m_old[l]));
            end
         end
      end
      if (!rst) begin
         modelReset();
         m_live = 1;
      end else if (m_live) begin
         if (in_valid && exp_ready) begin
            for (int l = 0; l < W; l++) begin
               logic [31:0] ins;
               bit kn, hrd, hr1, hr2;
               int s1, s2, tag, old, rd;
               ins = in_instr[l*32 +: 32];
               dec(ins, kn, hrd, hr1, hr2);
               rd = int'(ins[11:7]);
               s1 = hr1 ? m_rat[ins[19:15]] : 0;
               s2 = hr2 ? m_rat[ins[24:20]] : 0;
               tag = 0;
               old = 0;
               if (laneAllocs(ins, in_lane_valid[l])) begin
                  tag = m_free.pop_front();
                  m_spec.push_back(tag);
                  if (rd != 0) begin
                     old = m_rat[rd];
                     m_rat[rd] = tag;
                  end
               end
               m_instr[l] = (in_lane_valid[l] && kn) ? {8'd0, ins, 6'(s2), 6'(s1), 6'(tag)} : '0;
               m_arch[l]  = (in_lane_valid[l] && hrd) ? rd : 0;
               m_phys[l]  = tag;
               m_old[l]   = old;
            end
            m_lv = in_lane_valid;
            m_out_valid = 1;
         end else if (out_ready) begin
            m_out_valid = 0;
         end
         for (int l = 0; l < W; l++) begin
            if (commit_valid[l]) begin
               int a, p, o;
               a = int'(commit_arch_rd[l*5 +: 5]);
               p = int'(commit_phys_rd[l*PW +: PW]);
               o = int'(commit_old_phys_rd[l*PW +: PW]);
               if (a != 0) m_rrat[a] = p;
               if (p != 0) begin
                  m_free.push_back((a == 0) ? p : o);
                  void'(m_spec.pop_front());
               end
            end
         end
         if (flush) begin
            m_free = {m_spec, m_free};
            m_spec.delete();
            m_rat = m_rrat;
            m_out_valid = 0;
         end
      end
   end

   function automatic logic [31:0] rtype(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
      return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
   endfunction

   function automatic logic [31:0] beq(input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
   endfunction

   task automatic applyStimulus(input bit v, input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1);
      in_valid = v;
      in_lane_valid = lv;
      in_instr = {i1, i0};
   endtask

   task automatic setCommit(input bit cv, input int arch, input int phys, input int old);
      commit_valid       = {1'b0, cv};
      commit_arch_rd     = {5'd0, 5'(arch)};
      commit_phys_rd     = {6'd0, 6'(phys)};
      commit_old_phys_rd = {6'd0, 6'(old)};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      setCommit(0, 0, 0, 0);
      flush = 0;
      out_ready = 1;
      rst = 0;
      step();
      step();
      rst = 1;
      step();
   endtask

   initial begin
      doReset();
      checkOutput("reset_free_count", 64'(free_count), 64'd32);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_out_phys", 64'(out_phys_rd), 64'd0);

      applyStimulus(1, 2'b01, addi(5, 0, 1), 32'd0);
      step();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      checkOutput("addi_prd", 64'(out_phys_rd[PW-1:0]), 64'd32);
      checkOutput("addi_old", 64'(out_old_phys_rd[PW-1:0]), 64'd5);
      checkOutput("addi_prs1", 64'(out_instr[PW +: PW]), 64'd0);
      checkOutput("addi_free", 64'(free_count), 64'd31);
      step();

      doReset();
      applyStimulus(1, 2'b11, rtype(7'd0, 3, 1, 2), rtype(7'b0100000, 4, 3, 3));
      step();
      checkOutput("grp_l0_prs1", 64'(out_instr[PW +: PW]), 64'd1);
      checkOutput("grp_l0_prs2", 64'(out_instr[2*PW +: PW]), 64'd2);
      checkOutput("grp_l1_prs1", 64'(out_instr[IW+PW +: PW]), 64'd32);
      checkOutput("grp_l1_prs2", 64'(out_instr[IW+2*PW +: PW]), 64'd32);
      checkOutput("grp_l1_prd", 64'(out_phys_rd[PW +: PW]), 64'd33);
      applyStimulus(1, 2'b11, rtype(7'd0, 10, 3, 4), 32'hFFFF_FFFF);
      step();
      checkOutput("rat3", 64'(out_instr[PW +: PW]), 64'd32);
      checkOutput("rat4", 64'(out_instr[2*PW +: PW]), 64'd33);
      checkOutput("unknown_instr", 64'(out_instr[IW +: IW]), 64'd0);
      applyStimulus(1, 2'b01, beq(10, 3), 32'd0);
      step();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      checkOutput("beq_prd", 64'(out_phys_rd[PW-1:0]), 64'd0);
      checkOutput("beq_prs1", 64'(out_instr[PW +: PW]), 64'd34);
      step();

      doReset();
      for (int k = 0; k < 15; k++) begin
         applyStimulus(1, 2'b11, addi(2*k + 1, 0, k), addi(2*k + 2, 0, k));
         step();
      end
      applyStimulus(1, 2'b01, addi(31, 0, 0), 32'd0);
      step();
      applyStimulus(1, 2'b11, addi(7, 0, 0), addi(8, 0, 0));
      #1;
      checkOutput("exhaust_free", 64'(free_count), 64'd1);
      checkOutput("exhaust_stall", 64'(in_ready), 64'd0);
      setCommit(1, 1, 32, 1);
      #1;
      checkOutput("commit_not_bypassed", 64'(in_ready), 64'd0);
      step();
      setCommit(0, 0, 0, 0);
      checkOutput("after_commit_free", 64'(free_count), 64'd2);
      checkOutput("after_commit_ready", 64'(in_ready), 64'd1);
      step();
      checkOutput("wrap_l0_prd", 64'(out_phys_rd[PW-1:0]), 64'd63);
      checkOutput("wrap_l1_prd", 64'(out_phys_rd[PW +: PW]), 64'd1);
      checkOutput("empty_free", 64'(free_count), 64'd0);
      applyStimulus(1, 2'b01, beq(1, 2), 32'd0);
      #1;
      checkOutput("empty_noalloc_ready", 64'(in_ready), 64'd1);
      step();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      step();

      doReset();
      out_ready = 0;
      applyStimulus(1, 2'b01, addi(5, 0, 1), 32'd0);
      step();
      applyStimulus(1, 2'b01, rtype(7'd0, 6, 5, 5), 32'd0);
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_ready", 64'(in_ready), 64'd0);
         checkOutput("bp_hold_prd", 64'(out_phys_rd[PW-1:0]), 64'd32);
         step();
      end
      out_ready = 1;
      #1;
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
      step();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      checkOutput("bp_prs1", 64'(out_instr[PW +: PW]), 64'd32);
      checkOutput("bp_prd", 64'(out_phys_rd[PW-1:0]), 64'd33);
      step();

      doReset();
      applyStimulus(1, 2'b11, addi(5, 0, 1), addi(6, 0, 2));
      step();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      checkOutput("fl_l1_prd", 64'(out_phys_rd[PW +: PW]), 64'd33);
      setCommit(1, 5, 32, 5);
      flush = 1;
      step();
      setCommit(0, 0, 0, 0);
      flush = 0;
      checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
      checkOutput("fl_free", 64'(free_count), 64'd32);
      applyStimulus(1, 2'b01, rtype(7'd0, 7, 5, 6), 32'd0);
      step();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      checkOutput("fl_rat5", 64'(out_instr[PW +: PW]), 64'd32);
      checkOutput("fl_rat6", 64'(out_instr[2*PW +: PW]), 64'd6);
      checkOutput("fl_realloc", 64'(out_phys_rd[PW-1:0]), 64'd33);
      step();

      doReset();
      applyStimulus(1, 2'b01, addi(0, 0, 1), 32'd0);
      step();
      applyStimulus(0, 2'b00, 32'd0, 32'd0);
      checkOutput("x0_free", 64'(free_count), ELIDE ? 64'd32 : 64'd31);
      checkOutput("x0_prd", 64'(out_phys_rd[PW-1:0]), ELIDE ? 64'd0 : 64'd32);
      checkOutput("x0_old", 64'(out_old_phys_rd[PW-1:0]), 64'd0);
      setCommit(1, 0, ELIDE ? 0 : 32, 0);
      step();
      setCommit(0, 0, 0, 0);
      checkOutput("x0_commit_free", 64'(free_count), 64'd32);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
